// File: rtl/seq_det_sched.sv
// seq_det_sched: one "101" Moore detector shared by four serial requesters.
// A round-robin scheduler (IDLE/RUN/DONE) grants one requester a whole frame.
// The frame runs until that requester's dlast bit. The frame's match count is
// reported with a one-cycle done pulse.
// Build option: define SEQ_DET_OVERLAP_EN for overlapping matches.
// Without it, a match restarts the search from scratch.
module seq_det_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       din,
  input  logic [3:0]       dlast,
  output logic [3:0]       gnt,
  output logic             Y,
  output logic             done,
  output logic [1:0]       done_id,
  output logic [CNT_W-1:0] match_cnt
);

  // Scheduler states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Detector states: S1 = seen "1", S2 = seen "10", S3 = seen "101"
  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;
  localparam logic [1:0] S3 = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       det_q, det_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] winIdx;
  logic       winValid;
  logic [1:0] cand;
  logic       curBit;
  logic       curLast;

  assign curBit  = din[idx_q];
  assign curLast = dlast[idx_q];

  // One step of the "101" detector.
  // S3 on a 0 decides whether matches may share bits.
  function automatic logic [1:0] detStep(input logic [1:0] s, input logic b);
    logic [1:0] nxt;
    case (s)
      S0:      nxt = b ? S1 : S0;
      S1:      nxt = b ? S1 : S2;
      S2:      nxt = b ? S3 : S0;
`ifdef SEQ_DET_OVERLAP_EN
      default: nxt = b ? S1 : S2;
`else
      default: nxt = b ? S1 : S0;
`endif
    endcase
    return nxt;
  endfunction

  // Round-robin search starting at ptr_q.
  // The loop scans downward so the closest requester after the pointer is the last one written.
  always_comb begin
    winIdx   = 2'd0;
    winValid = 1'b0;
    cand     = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) begin
        winIdx   = cand;
        winValid = 1'b1;
      end
    end
  end

  // Next-state logic for the scheduler, detector and match counter
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    det_d   = det_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (winValid) begin
          state_d = RUN;
          idx_d   = winIdx;
          det_d   = S0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        det_d = detStep(det_q, curBit);
        if (det_d == S3 && cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (curLast) begin
          state_d = DONE;
          ptr_d   = idx_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        det_d   = S0;
      end
      default: begin
        state_d = IDLE;
        det_d   = S0;
      end
    endcase
  end

  // State registers with synchronous reset.
  // The pointer moves only on a completed frame, so an aborted frame earns no credit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      ptr_q   <= 2'd0;
      det_q   <= S0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      det_q   <= det_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = (state_q == RUN) ? (4'b0001 << idx_q) : 4'b0000;
  assign Y         = (det_q == S3);
  assign done      = (state_q == DONE);
  assign done_id   = done ? idx_q : 2'd0;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched: directed bench for seq_det_sched.
// A frame-level model in the bench computes the expected outputs on every cycle.
// Matches are found by scanning the consumed bit history.
// Two instances are driven with the same stimulus: CNT_W=8 and CNT_W=2.
module tb_seq_det_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, din, dlast;

  logic [3:0] gnt, gnt2;
  logic       Y, Y2, done, done2;
  logic [1:0] doneId, doneId2;
  logic [7:0] matchCnt;
  logic [1:0] matchCnt2;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

`ifdef SEQ_DET_OVERLAP_EN
  localparam int EXP_10101 = 2;
`else
  localparam int EXP_10101 = 1;
`endif

  always #5 clk = ~clk;

  seq_det_sched #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .dlast(dlast),
    .gnt(gnt), .Y(Y), .done(done), .done_id(doneId), .match_cnt(matchCnt)
  );

  seq_det_sched #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req(req), .din(din), .dlast(dlast),
    .gnt(gnt2), .Y(Y2), .done(done2), .done_id(doneId2), .match_cnt(matchCnt2)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Frame-level model: phase 0 idle, 1 serving a frame, 2 reporting
  int mPhase = 0, mIdx = 0, mPtr = 0, mCnt = 0, mLastEnd = 0;
  bit mY = 1'b0;
  bit bits[$];
  int n;
  bit hit;

  always @(posedge clk) begin
    if (rst) begin
      mPhase = 0; mIdx = 0; mPtr = 0; mCnt = 0; mY = 1'b0;
      bits.delete();
    end else begin
      case (mPhase)
        0: begin
          for (int k = 0; k < 4; k++) begin
            if (mPhase == 0 && req[(mPtr + k) % 4]) begin
              mIdx = (mPtr + k) % 4;
              mPhase = 1;
            end
          end
          if (mPhase == 1) begin
            mCnt = 0; mY = 1'b0; mLastEnd = 0;
            bits.delete();
          end
        end
        1: begin
          bits.push_back(din[mIdx]);
          n = bits.size();
          hit = (n >= 3) && bits[n-3] && !bits[n-2] && bits[n-1];
`ifndef SEQ_DET_OVERLAP_EN
          hit = hit && (n - mLastEnd >= 3);
`endif
          mY = hit;
          if (hit) begin
            mCnt++;
            mLastEnd = n;
          end
          if (dlast[mIdx]) begin
            mPhase = 2;
            mPtr = (mIdx + 1) % 4;
          end
        end
        default: begin
          mPhase = 0;
          mY = 1'b0;
        end
      endcase
    end
  end

  // Per-cycle comparison of both instances against the model, plus grant logging
  logic [3:0] prevGnt = 4'b0;
  int grantLog[$];
  int expG, expCnt8, expCnt2;
  bit expY, expDone;
  int expId;

  always @(negedge clk) begin
    if (checkEn) begin
      expG    = (mPhase == 1) ? (1 << mIdx) : 0;
      expY    = (mPhase != 0) && mY;
      expDone = (mPhase == 2);
      expId   = expDone ? mIdx : 0;
      expCnt8 = (mCnt > 255) ? 255 : mCnt;
      expCnt2 = (mCnt > 3) ? 3 : mCnt;
      checkOutput("gnt", 32'(gnt), 32'(expG));
      checkOutput("Y", 32'(Y), 32'(expY));
      checkOutput("done", 32'(done), 32'(expDone));
      checkOutput("done_id", 32'(doneId), 32'(expId));
      checkOutput("match_cnt", 32'(matchCnt), 32'(expCnt8));
      checkOutput("gnt_w2", 32'(gnt2), 32'(expG));
      checkOutput("Y_w2", 32'(Y2), 32'(expY));
      checkOutput("done_w2", 32'(done2), 32'(expDone));
      checkOutput("done_id_w2", 32'(doneId2), 32'(expId));
      checkOutput("match_cnt_w2", 32'(matchCnt2), 32'(expCnt2));
      if (gnt != 4'b0 && prevGnt == 4'b0) begin
        for (int k = 0; k < 4; k++) if (gnt[k]) grantLog.push_back(k);
      end
      prevGnt = gnt;
    end
  end

  // Drive one cycle of inputs and return at the following falling edge
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d, input logic [3:0] l);
    req = r; din = d; dlast = l;
    @(negedge clk);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(4'b0, 4'b0, 4'b0);
    applyStimulus(4'b0, 4'b0, 4'b0);
    rst = 1'b0;
  endtask

  // Wait for any grant, then send an n-bit frame (MSB of pat first) on all lanes.
  // The task ends at the falling edge of the done cycle.
  task automatic sendFrame(input logic [3:0] reqHold, input logic [3:0] reqMid,
                           input int n, input logic [15:0] pat, output int waited);
    logic b;
    waited = 0;
    while (gnt == 4'b0 && waited < 20) begin
      applyStimulus(reqHold, 4'b0, 4'b0);
      waited++;
    end
    if (gnt == 4'b0) checkOutput("grant_timeout", 32'(waited), 32'(0));
    for (int k = 0; k < n; k++) begin
      b = pat[n-1-k];
      applyStimulus((k == 0) ? reqHold : reqMid, {4{b}}, (k == n-1) ? 4'hF : 4'h0);
    end
  endtask

  logic [5:0] t1Bits;
  int waited;

  initial begin
    rst = 1'b1; req = 4'b0; din = 4'b0; dlast = 4'b0;
    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset_gnt", 32'(gnt), 32'(0));
    checkOutput("reset_Y", 32'(Y), 32'(0));
    checkOutput("reset_done", 32'(done), 32'(0));
    checkOutput("reset_cnt", 32'(matchCnt), 32'(0));
    rst = 1'b0;

    // Requester 0 sends 101101; matches complete on bits 3 and 6
    $display("[TB] frame 101101 on requester 0");
    applyStimulus(4'b0001, 4'b0, 4'b0);
    checkOutput("t1_gnt", 32'(gnt), 32'(1));
    t1Bits = 6'b101101;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(4'b0001, {3'b0, t1Bits[5-k]}, (k == 5) ? 4'b0001 : 4'b0);
      if (k == 2) checkOutput("t1_Y_bit3", 32'(Y), 32'(1));
      if (k == 3) checkOutput("t1_Y_bit4", 32'(Y), 32'(0));
    end
    checkOutput("t1_done", 32'(done), 32'(1));
    checkOutput("t1_Y_done", 32'(Y), 32'(1));
    checkOutput("t1_done_id", 32'(doneId), 32'(0));
    checkOutput("t1_cnt", 32'(matchCnt), 32'(2));
    applyStimulus(4'b0, 4'b0, 4'b0);
    checkOutput("t1_idle_gnt", 32'(gnt), 32'(0));
    checkOutput("t1_idle_done", 32'(done), 32'(0));

    // All four requesting: rotation from reset, with idle gaps between frames
    $display("[TB] round robin with req=1111");
    resetDut();
    grantLog.delete();
    for (int f = 0; f < 5; f++) begin
      sendFrame(4'hF, 4'hF, 2, 16'b10, waited);
      checkOutput("rr_gap", 32'(waited >= 1), 32'(1));
    end
    applyStimulus(4'b0, 4'b0, 4'b0);
    applyStimulus(4'b0, 4'b0, 4'b0);
    checkOutput("rr_count", 32'(grantLog.size()), 32'(5));
    if (grantLog.size() == 5) begin
      checkOutput("rr_0", 32'(grantLog[0]), 32'(0));
      checkOutput("rr_1", 32'(grantLog[1]), 32'(1));
      checkOutput("rr_2", 32'(grantLog[2]), 32'(2));
      checkOutput("rr_3", 32'(grantLog[3]), 32'(3));
      checkOutput("rr_4", 32'(grantLog[4]), 32'(0));
    end

    // Requester 1 sends 10101: the build option decides overlap
    $display("[TB] frame 10101 on requester 1");
    sendFrame(4'b0010, 4'b0010, 5, 16'b10101, waited);
    checkOutput("ovl_done_id", 32'(doneId), 32'(1));
    checkOutput("ovl_cnt", 32'(matchCnt), 32'(EXP_10101));
    applyStimulus(4'b0, 4'b0, 4'b0);

    // Requester 2 drops its request after the first bit; the grant holds until dlast
    $display("[TB] request dropped mid-frame on requester 2");
    sendFrame(4'b0100, 4'b0000, 5, 16'b11010, waited);
    checkOutput("drop_done", 32'(done), 32'(1));
    checkOutput("drop_done_id", 32'(doneId), 32'(2));
    checkOutput("drop_cnt", 32'(matchCnt), 32'(1));
    applyStimulus(4'b0, 4'b0, 4'b0);

    // 101 repeated five times: the 2-bit counter saturates at 3
    $display("[TB] five matches, saturation check");
    sendFrame(4'b0001, 4'b0001, 15, 16'h5B6D, waited);
    checkOutput("sat_cnt8", 32'(matchCnt), 32'(5));
    checkOutput("sat_cnt2", 32'(matchCnt2), 32'(3));
    applyStimulus(4'b0, 4'b0, 4'b0);

    // Reset during the third RUN cycle aborts the frame
    $display("[TB] reset mid-frame");
    applyStimulus(4'b0010, 4'b0, 4'b0);
    checkOutput("abort_gnt", 32'(gnt), 32'(2));
    applyStimulus(4'b0010, 4'b0010, 4'b0);
    applyStimulus(4'b0010, 4'b0000, 4'b0);
    rst = 1'b1;
    applyStimulus(4'b0010, 4'b0010, 4'b0);
    rst = 1'b0;
    checkOutput("abort_gnt_off", 32'(gnt), 32'(0));
    checkOutput("abort_Y", 32'(Y), 32'(0));
    checkOutput("abort_done", 32'(done), 32'(0));
    checkOutput("abort_cnt", 32'(matchCnt), 32'(0));
    applyStimulus(4'b0, 4'b0, 4'b0);
    checkOutput("abort_done2", 32'(done), 32'(0));
    applyStimulus(4'b1111, 4'b0, 4'b0);
    checkOutput("abort_regrant", 32'(gnt), 32'(1));
    applyStimulus(4'b0, 4'b0, 4'b1111);
    checkOutput("abort_final_done", 32'(done), 32'(1));
    applyStimulus(4'b0, 4'b0, 4'b0);
    applyStimulus(4'b0, 4'b0, 4'b0);

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
